// File: rtl/axi4lite_pkg.sv
// Shared constants and state encodings for the AXI4-Lite register responder.
package axi4lite_pkg;

  localparam int unsigned ADDR_LSB = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WIdle,
    WResp
  } w_state_e;

  typedef enum logic {
    RIdle,
    RData
  } r_state_e;

  function automatic logic [1:0] resp_code(input logic in_range);
    return in_range ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi4lite_regfile.sv
// Register array with a byte-strobed write port, combinational read port and flat view.
module axi4lite_regfile
  import axi4lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_we,
  input  logic [IDX_W-1:0]               i_widx,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  input  logic [DATA_WIDTH/8-1:0]        i_wstrb,
  input  logic [IDX_W-1:0]               i_ridx,
  output logic [DATA_WIDTH-1:0]          o_rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_reg_out
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      for (int k = 0; k < int'(STRB_W); k++) begin
        if (i_wstrb[k]) begin
          r_regs[i_widx][8*k +: 8] <= i_wdata[8*k +: 8];
        end
      end
    end
  end

  assign o_rdata = r_regs[i_ridx];

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
    assign o_reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
  end

endmodule

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite responder exposing NUM_REGS registers; independent write and read channel FSMs,
// one outstanding transaction per direction, all readies registered.
module axi4lite_slave_regs
  import axi4lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 4
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_awvalid,
  output logic                           o_awready,
  input  logic [ADDR_WIDTH-1:0]          i_awaddr,
  input  logic                           i_wvalid,
  output logic                           o_wready,
  input  logic [DATA_WIDTH-1:0]          i_wdata,
  input  logic [DATA_WIDTH/8-1:0]        i_wstrb,
  output logic                           o_bvalid,
  input  logic                           i_bready,
  output logic [1:0]                     o_bresp,
  input  logic                           i_arvalid,
  output logic                           o_arready,
  input  logic [ADDR_WIDTH-1:0]          i_araddr,
  output logic                           o_rvalid,
  input  logic                           i_rready,
  output logic [DATA_WIDTH-1:0]          o_rdata,
  output logic [1:0]                     o_rresp,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_reg_out
);

  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("axi4lite_slave_regs supports DATA_WIDTH = 32 only");
  end
  if (NUM_REGS < 2 || (1 << IDX_W) != NUM_REGS) begin : g_bad_regs
    $error("NUM_REGS must be a power of two and at least 2");
  end

  // Write channel state
  w_state_e              r_w_state, w_w_state_d;
  logic                  r_aw_held, w_aw_held_d;
  logic                  r_w_held, w_w_held_d;
  logic [ADDR_WIDTH-1:0] r_awaddr, w_awaddr_d;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_d;
  logic [STRB_W-1:0]     r_wstrb, w_wstrb_d;
  logic                  r_awready, w_awready_d;
  logic                  r_wready, w_wready_d;
  logic                  r_bvalid, w_bvalid_d;
  logic [1:0]            r_bresp, w_bresp_d;
  logic                  w_we;
  logic                  w_aw_in_range;

  // Read channel state
  r_state_e              r_r_state, w_r_state_d;
  logic                  r_arready, w_arready_d;
  logic                  r_rvalid, w_rvalid_d;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_d;
  logic [1:0]            r_rresp, w_rresp_d;
  logic                  w_ar_in_range;
  logic [DATA_WIDTH-1:0] w_rf_rdata;

  logic                  w_unused_addr_lsbs;

  // Address bits above the register index must all be zero to hit a register.
  assign w_aw_in_range = ((r_awaddr >> (ADDR_LSB + IDX_W)) == '0);
  assign w_ar_in_range = ((i_araddr >> (ADDR_LSB + IDX_W)) == '0);
  assign w_unused_addr_lsbs = ^{r_awaddr[ADDR_LSB-1:0], i_araddr[ADDR_LSB-1:0]};

  axi4lite_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_we      (w_we),
    .i_widx    (r_awaddr[ADDR_LSB +: IDX_W]),
    .i_wdata   (r_wdata),
    .i_wstrb   (r_wstrb),
    .i_ridx    (i_araddr[ADDR_LSB +: IDX_W]),
    .o_rdata   (w_rf_rdata),
    .o_reg_out (o_reg_out)
  );

  always_comb begin
    w_w_state_d = r_w_state;
    w_aw_held_d = r_aw_held;
    w_w_held_d  = r_w_held;
    w_awaddr_d  = r_awaddr;
    w_wdata_d   = r_wdata;
    w_wstrb_d   = r_wstrb;
    w_bvalid_d  = r_bvalid;
    w_bresp_d   = r_bresp;
    w_we        = 1'b0;
    case (r_w_state)
      WIdle: begin
        if (i_awvalid && r_awready) begin
          w_awaddr_d  = i_awaddr;
          w_aw_held_d = 1'b1;
        end
        if (i_wvalid && r_wready) begin
          w_wdata_d  = i_wdata;
          w_wstrb_d  = i_wstrb;
          w_w_held_d = 1'b1;
        end
        // Both halves were captured on earlier edges; readies are low so nothing new arrives.
        if (r_aw_held && r_w_held) begin
          w_we        = w_aw_in_range;
          w_bvalid_d  = 1'b1;
          w_bresp_d   = resp_code(w_aw_in_range);
          w_aw_held_d = 1'b0;
          w_w_held_d  = 1'b0;
          w_w_state_d = WResp;
        end
      end
      WResp: begin
        if (i_bready) begin
          w_bvalid_d  = 1'b0;
          w_w_state_d = WIdle;
        end
      end
      default: w_w_state_d = WIdle;
    endcase
    w_awready_d = (w_w_state_d == WIdle) && !w_aw_held_d;
    w_wready_d  = (w_w_state_d == WIdle) && !w_w_held_d;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_w_state <= WIdle;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_w_state <= w_w_state_d;
      r_aw_held <= w_aw_held_d;
      r_w_held  <= w_w_held_d;
      r_awaddr  <= w_awaddr_d;
      r_wdata   <= w_wdata_d;
      r_wstrb   <= w_wstrb_d;
      r_awready <= w_awready_d;
      r_wready  <= w_wready_d;
      r_bvalid  <= w_bvalid_d;
      r_bresp   <= w_bresp_d;
    end
  end

  always_comb begin
    w_r_state_d = r_r_state;
    w_rvalid_d  = r_rvalid;
    w_rdata_d   = r_rdata;
    w_rresp_d   = r_rresp;
    case (r_r_state)
      RIdle: begin
        // Regfile read is combinational, so a same-edge write is not yet visible here.
        if (i_arvalid && r_arready) begin
          w_rvalid_d  = 1'b1;
          w_rdata_d   = w_ar_in_range ? w_rf_rdata : '0;
          w_rresp_d   = resp_code(w_ar_in_range);
          w_r_state_d = RData;
        end
      end
      RData: begin
        if (i_rready) begin
          w_rvalid_d  = 1'b0;
          w_r_state_d = RIdle;
        end
      end
      default: w_r_state_d = RIdle;
    endcase
    w_arready_d = (w_r_state_d == RIdle);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_r_state <= RIdle;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_r_state <= w_r_state_d;
      r_arready <= w_arready_d;
      r_rvalid  <= w_rvalid_d;
      r_rdata   <= w_rdata_d;
      r_rresp   <= w_rresp_d;
    end
  end

  assign o_awready = r_awready;
  assign o_wready  = r_wready;
  assign o_bvalid  = r_bvalid;
  assign o_bresp   = r_bresp;
  assign o_arready = r_arready;
  assign o_rvalid  = r_rvalid;
  assign o_rdata   = r_rdata;
  assign o_rresp   = r_rresp;

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Drives a 4-register and a 2-register responder with shared stimulus and checks both
// against a transaction-level model every cycle.
module tb_axi4lite_slave_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [3:0]  awaddr, araddr, wstrb;
  logic [31:0] wdata;

  logic         a_awready, a_wready, a_bvalid, a_arready, a_rvalid;
  logic [1:0]   a_bresp, a_rresp;
  logic [31:0]  a_rdata;
  logic [127:0] a_reg_out;
  logic         b_awready, b_wready, b_bvalid, b_arready, b_rvalid;
  logic [1:0]   b_bresp, b_rresp;
  logic [31:0]  b_rdata;
  logic [63:0]  b_reg_out;

  int checks = 0;
  int failures = 0;

  // Model state: shared handshake timing, per-instance contents and responses
  logic [31:0] m4 [4];
  logic [31:0] m2 [2];
  bit          e_awready, e_wready, e_arready, e_bvalid, e_rvalid;
  logic [1:0]  e_bresp4, e_bresp2, e_rresp4, e_rresp2;
  logic [31:0] e_rdata4, e_rdata2;
  bit          h_aw, h_w;
  logic [3:0]  h_addr, h_strb;
  logic [31:0] h_data;
  bit          last_aw_hs, last_w_hs, last_ar_hs;
  int          b_hs_cnt;

  always #5 clk = ~clk;

  axi4lite_slave_regs #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(4)) u_dut4 (
    .i_clk(clk), .i_reset(reset),
    .i_awvalid(awvalid), .o_awready(a_awready), .i_awaddr(awaddr),
    .i_wvalid(wvalid), .o_wready(a_wready), .i_wdata(wdata), .i_wstrb(wstrb),
    .o_bvalid(a_bvalid), .i_bready(bready), .o_bresp(a_bresp),
    .i_arvalid(arvalid), .o_arready(a_arready), .i_araddr(araddr),
    .o_rvalid(a_rvalid), .i_rready(rready), .o_rdata(a_rdata), .o_rresp(a_rresp),
    .o_reg_out(a_reg_out)
  );

  axi4lite_slave_regs #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(2)) u_dut2 (
    .i_clk(clk), .i_reset(reset),
    .i_awvalid(awvalid), .o_awready(b_awready), .i_awaddr(awaddr),
    .i_wvalid(wvalid), .o_wready(b_wready), .i_wdata(wdata), .i_wstrb(wstrb),
    .o_bvalid(b_bvalid), .i_bready(bready), .o_bresp(b_bresp),
    .i_arvalid(arvalid), .o_arready(b_arready), .i_araddr(araddr),
    .o_rvalid(b_rvalid), .i_rready(rready), .o_rdata(b_rdata), .o_rresp(b_rresp),
    .o_reg_out(b_reg_out)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic chk1(input string n, input logic a, input logic e);
    chk(n, 128'(a), 128'(e));
  endtask
  task automatic chk2(input string n, input logic [1:0] a, input logic [1:0] e);
    chk(n, 128'(a), 128'(e));
  endtask
  task automatic chk32(input string n, input logic [31:0] a, input logic [31:0] e);
    chk(n, 128'(a), 128'(e));
  endtask

  function automatic bit in_rng(input int n, input logic [3:0] a);
    return int'(a) < 4 * n;
  endfunction
  function automatic int idx_of(input int n, input logic [3:0] a);
    return (int'(a) / 4) % n;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m4[i] = '0;
    for (int i = 0; i < 2; i++) m2[i] = '0;
    {e_awready, e_wready, e_arready, e_bvalid, e_rvalid} = '0;
    {e_bresp4, e_bresp2, e_rresp4, e_rresp2} = '0;
    e_rdata4 = '0; e_rdata2 = '0;
    h_aw = 0; h_w = 0;
    {last_aw_hs, last_w_hs, last_ar_hs} = '0;
  endtask

  // One rising edge of the specified behaviour, applied to the model.
  task automatic model_step();
    bit aw_hs, w_hs, ar_hs;
    if (reset) begin
      model_reset();
      return;
    end
    aw_hs = awvalid && e_awready;
    w_hs  = wvalid && e_wready;
    ar_hs = arvalid && e_arready;
    last_aw_hs = aw_hs; last_w_hs = w_hs; last_ar_hs = ar_hs;
    // Reads observe contents from before any write on this edge.
    if (e_rvalid) begin
      if (rready) e_rvalid = 0;
    end else if (ar_hs) begin
      e_rvalid = 1;
      e_rdata4 = in_rng(4, araddr) ? m4[idx_of(4, araddr)] : 32'h0;
      e_rdata2 = in_rng(2, araddr) ? m2[idx_of(2, araddr)] : 32'h0;
      e_rresp4 = in_rng(4, araddr) ? 2'b00 : 2'b10;
      e_rresp2 = in_rng(2, araddr) ? 2'b00 : 2'b10;
    end
    if (e_bvalid) begin
      if (bready) e_bvalid = 0;
    end else if (h_aw && h_w) begin
      if (in_rng(4, h_addr)) m4[idx_of(4, h_addr)] = merge(m4[idx_of(4, h_addr)], h_data, h_strb);
      if (in_rng(2, h_addr)) m2[idx_of(2, h_addr)] = merge(m2[idx_of(2, h_addr)], h_data, h_strb);
      e_bresp4 = in_rng(4, h_addr) ? 2'b00 : 2'b10;
      e_bresp2 = in_rng(2, h_addr) ? 2'b00 : 2'b10;
      e_bvalid = 1;
      h_aw = 0; h_w = 0;
    end else begin
      if (aw_hs) begin h_aw = 1; h_addr = awaddr; end
      if (w_hs) begin h_w = 1; h_data = wdata; h_strb = wstrb; end
    end
    e_awready = !e_bvalid && !h_aw;
    e_wready  = !e_bvalid && !h_w;
    e_arready = !e_rvalid;
  endtask

  task automatic compare_all();
    chk1("awready4", a_awready, e_awready);  chk1("awready2", b_awready, e_awready);
    chk1("wready4", a_wready, e_wready);     chk1("wready2", b_wready, e_wready);
    chk1("arready4", a_arready, e_arready);  chk1("arready2", b_arready, e_arready);
    chk1("bvalid4", a_bvalid, e_bvalid);     chk1("bvalid2", b_bvalid, e_bvalid);
    chk1("rvalid4", a_rvalid, e_rvalid);     chk1("rvalid2", b_rvalid, e_rvalid);
    if (e_bvalid) begin
      chk2("bresp4", a_bresp, e_bresp4);     chk2("bresp2", b_bresp, e_bresp2);
    end
    if (e_rvalid) begin
      chk32("rdata4", a_rdata, e_rdata4);    chk32("rdata2", b_rdata, e_rdata2);
      chk2("rresp4", a_rresp, e_rresp4);     chk2("rresp2", b_rresp, e_rresp2);
    end
    chk("reg_out4", a_reg_out, {m4[3], m4[2], m4[1], m4[0]});
    chk("reg_out2", 128'(b_reg_out), 128'({m2[1], m2[0]}));
    if (a_bvalid && bready) b_hs_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    awvalid = 1; awaddr = a; wvalid = 1; wdata = d; wstrb = s;
  endtask

  initial begin
    reset = 1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
    model_reset();
    b_hs_cnt = 0;

    // Reset held for two cycles, readies rise on the first edge after release
    tick(); tick();
    chk1("rst_awready", a_awready, 1'b0);
    chk32("rst_rdata", a_rdata, 32'h0);
    reset = 0;
    tick();
    chk1("post_rst_awready", a_awready, 1'b1);
    chk1("post_rst_arready", b_arready, 1'b1);

    // Same-cycle AW+W
    bready = 1; rready = 1;
    set_write(4'h4, 32'hDEADBEEF, 4'hF);
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    chk1("sc_bvalid", a_bvalid, 1'b1);
    chk2("sc_bresp", a_bresp, 2'b00);
    chk32("sc_reg1", a_reg_out[63:32], 32'hDEADBEEF);
    chk32("sc_model_reg1", m4[1], 32'hDEADBEEF);
    tick();
    arvalid = 1; araddr = 4'h4;
    tick();
    arvalid = 0;
    chk32("sc_rdata", a_rdata, 32'hDEADBEEF);
    chk2("sc_rresp", a_rresp, 2'b00);
    tick();

    // W first, AW three cycles later
    b_hs_cnt = 0;
    wvalid = 1; wdata = 32'h12345678; wstrb = 4'b0101;
    tick();
    wvalid = 0;
    tick();
    chk1("split_wready", a_wready, 1'b0);
    tick();
    awvalid = 1; awaddr = 4'h8;
    tick();
    awvalid = 0;
    tick();
    chk32("split_reg2", a_reg_out[95:64], 32'h00340078);
    chk2("split_bresp2", b_bresp, 2'b10);
    tick(); tick(); tick();
    chk("split_one_b", 128'(b_hs_cnt), 128'(1));

    // Out-of-range for the 2-register instance
    set_write(4'hC, 32'hA5A5A5A5, 4'hF);
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    chk2("oor_bresp", b_bresp, 2'b10);
    chk("oor_regs", 128'(b_reg_out), 128'({32'hDEADBEEF, 32'h0}));
    tick();
    arvalid = 1; araddr = 4'hC;
    tick();
    arvalid = 0;
    chk32("oor_rdata", b_rdata, 32'h0);
    chk2("oor_rresp", b_rresp, 2'b10);
    chk32("inr_rdata", a_rdata, 32'hA5A5A5A5);
    tick();

    // Backpressure on both responses
    bready = 0; rready = 0;
    set_write(4'h0, 32'h11111111, 4'hF);
    arvalid = 1; araddr = 4'h4;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    for (int i = 0; i < 6; i++) tick();
    chk1("bp_bvalid", a_bvalid, 1'b1);
    chk1("bp_rvalid", a_rvalid, 1'b1);
    chk1("bp_awready", a_awready, 1'b0);
    chk1("bp_arready", a_arready, 1'b0);
    chk32("bp_rdata", a_rdata, 32'hDEADBEEF);
    bready = 1; rready = 1;
    tick(); tick();

    // Read on the same edge the register is written returns the old value
    set_write(4'h0, 32'h22222222, 4'hF);
    tick();
    awvalid = 0; wvalid = 0;
    arvalid = 1; araddr = 4'h0;
    tick();
    arvalid = 0;
    chk32("rw_old4", a_rdata, 32'h11111111);
    chk32("rw_old2", b_rdata, 32'h11111111);
    tick();
    arvalid = 1;
    tick();
    arvalid = 0;
    chk32("rw_new4", a_rdata, 32'h22222222);
    tick();

    // Reset while a write response is pending
    bready = 0;
    set_write(4'h4, 32'h33333333, 4'hF);
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    chk1("pre_rst_bvalid", a_bvalid, 1'b1);
    reset = 1;
    model_reset();
    #1;
    chk1("rst_bvalid_drop", a_bvalid, 1'b0);
    chk("rst_regs", a_reg_out, 128'h0);
    tick(); tick();
    reset = 0; bready = 1;
    tick();
    chk1("rst_bvalid_low", a_bvalid, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (reset) begin
        reset = 0;
      end else if ($urandom_range(0, 399) == 0) begin
        reset = 1; awvalid = 0; wvalid = 0; arvalid = 0;
        model_reset();
      end
      if (!reset) begin
        if (!awvalid || last_aw_hs) begin
          awvalid = ($urandom_range(0, 2) == 0);
          awaddr  = 4'($urandom_range(0, 15));
        end
        if (!wvalid || last_w_hs) begin
          wvalid = ($urandom_range(0, 2) == 0);
          wdata  = $urandom;
          wstrb  = 4'($urandom_range(0, 15));
        end
        if (!arvalid || last_ar_hs) begin
          arvalid = ($urandom_range(0, 2) == 0);
          araddr  = 4'($urandom_range(0, 15));
        end
        bready = ($urandom_range(0, 1) == 1);
        rready = ($urandom_range(0, 1) == 1);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
